// File: rtl/knn_topk_tracker_if.sv
`default_nettype none
// =============================================================================
// Module   : knn_topk_tracker_if
// Purpose  : Sample, control and result handshake bundle for knn_topk_tracker.
// Revision : 1.0
// =============================================================================
interface knn_topk_tracker_if #(
  parameter int K      = 4,
  parameter int DIST_W = 32,
  parameter int ID_W   = 16
);
  localparam int CNT_W  = $clog2(K + 1);
  localparam int RANK_W = $clog2(K);

  logic              query_start_in;
  logic              data_valid_in;
  logic [DIST_W-1:0] distance_sq_in;
  logic [ID_W-1:0]   vertex_id_in;
  logic              query_done_in;
  logic              ready_out;
  logic [CNT_W-1:0]  count_out;
  logic              result_valid_out;
  logic              result_ready_in;
  logic [DIST_W-1:0] result_dist_out;
  logic [ID_W-1:0]   result_id_out;
  logic [RANK_W-1:0] result_rank_out;
  logic              result_last_out;
  logic              done_out;

  modport master (
    output query_start_in, data_valid_in, distance_sq_in, vertex_id_in,
           query_done_in, result_ready_in,
    input  ready_out, count_out, result_valid_out, result_dist_out,
           result_id_out, result_rank_out, result_last_out, done_out
  );

  modport slave (
    input  query_start_in, data_valid_in, distance_sq_in, vertex_id_in,
           query_done_in, result_ready_in,
    output ready_out, count_out, result_valid_out, result_dist_out,
           result_id_out, result_rank_out, result_last_out, done_out
  );
endinterface
`default_nettype wire

// File: rtl/knn_topk_tracker.sv
`default_nettype none
// =============================================================================
// Module   : knn_topk_tracker
// Purpose  : Keeps the K smallest (distance, id) pairs of a query sorted and
//            streams them nearest-first at end of query.
// Revision : 1.0
// =============================================================================
module knn_topk_tracker #(
  parameter int K      = 4,
  parameter int DIST_W = 32,
  parameter int ID_W   = 16
) (
  input logic               clk_in,
  input logic               rst_in,
  knn_topk_tracker_if.slave bus
);
  localparam int CNT_W  = $clog2(K + 1);
  localparam int RANK_W = $clog2(K);
  localparam logic [CNT_W-1:0] C_K = CNT_W'(K);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DRAIN   = 2'd2,
    S_FINISH  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [DIST_W-1:0] dist_q [K];
  logic [DIST_W-1:0] dist_d [K];
  logic [ID_W-1:0]   id_q   [K];
  logic [ID_W-1:0]   id_d   [K];
  logic [CNT_W-1:0]  count_q, count_d;
  logic [RANK_W-1:0] rank_q, rank_d;

  logic [K-1:0]      keep;
  logic [DIST_W-1:0] ins_dist [K];
  logic [ID_W-1:0]   ins_id   [K];
  logic              accept;
  logic              res_valid;
  logic              beat_last;
  logic              beat_fire;

  // keep[i]: slot i holds a valid entry no farther than the incoming sample,
  // so it stays; the first non-kept slot takes the sample, later ones shift.
  for (genvar i = 0; i < K; i++) begin : g_slot
    localparam logic [CNT_W-1:0] C_IDX = CNT_W'(i);
    assign keep[i] = (C_IDX < count_q) && (dist_q[i] <= bus.distance_sq_in);
    if (i == 0) begin : g_head
      assign ins_dist[i] = keep[i] ? dist_q[i] : bus.distance_sq_in;
      assign ins_id[i]   = keep[i] ? id_q[i]   : bus.vertex_id_in;
    end else begin : g_tail
      assign ins_dist[i] = keep[i]   ? dist_q[i]          :
                           keep[i-1] ? bus.distance_sq_in : dist_q[i-1];
      assign ins_id[i]   = keep[i]   ? id_q[i]            :
                           keep[i-1] ? bus.vertex_id_in   : id_q[i-1];
    end
  end

  assign accept    = (state_q == S_COLLECT) && bus.data_valid_in;
  assign res_valid = (state_q == S_DRAIN) && (count_q != '0);
  assign beat_last = (CNT_W'(rank_q) == (count_q - CNT_W'(1)));
  assign beat_fire = res_valid && bus.result_ready_in;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rank_d  = rank_q;
    dist_d  = dist_q;
    id_d    = id_q;
    if (bus.query_start_in) begin
      state_d = S_COLLECT;
      count_d = '0;
      rank_d  = '0;
      for (int i = 0; i < K; i++) begin
        dist_d[i] = '0;
        id_d[i]   = '0;
      end
    end else begin
      case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_COLLECT: begin
          // A full list whose last slot is <= the sample leaves keep[K-1] set.
          if (accept && !keep[K-1]) begin
            dist_d = ins_dist;
            id_d   = ins_id;
            if (count_q != C_K) count_d = count_q + CNT_W'(1);
          end
          if (bus.query_done_in) begin
            state_d = S_DRAIN;
            rank_d  = '0;
          end
        end
        S_DRAIN: begin
          if (count_q == '0) begin
            state_d = S_FINISH;
          end else if (beat_fire) begin
            if (beat_last) begin
              state_d = S_FINISH;
              rank_d  = '0;
            end else begin
              rank_d = rank_q + RANK_W'(1);
            end
          end
        end
        S_FINISH: state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= S_IDLE;
      count_q <= '0;
      rank_q  <= '0;
      for (int i = 0; i < K; i++) begin
        dist_q[i] <= '0;
        id_q[i]   <= '0;
      end
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rank_q  <= rank_d;
      dist_q  <= dist_d;
      id_q    <= id_d;
    end
  end

  assign bus.ready_out        = (state_q == S_COLLECT);
  assign bus.count_out        = count_q;
  assign bus.result_valid_out = res_valid;
  assign bus.result_dist_out  = res_valid ? dist_q[rank_q] : '0;
  assign bus.result_id_out    = res_valid ? id_q[rank_q]   : '0;
  assign bus.result_rank_out  = res_valid ? rank_q         : '0;
  assign bus.result_last_out  = res_valid && beat_last;
  // A restart arriving while in FINISH suppresses the completion pulse.
  assign bus.done_out         = (state_q == S_FINISH) && !bus.query_start_in;

endmodule
`default_nettype wire

// File: tb/tb_knn_topk_tracker.sv
`default_nettype none
// Bench for knn_topk_tracker: queue-based reference model checked every cycle,
// plus directed scenarios pinned with hand-computed results.
module tb_knn_topk_tracker;
  localparam int K      = 4;
  localparam int DIST_W = 32;
  localparam int ID_W   = 16;

  typedef struct {
    logic [DIST_W-1:0] d;
    logic [ID_W-1:0]   id;
  } ent_t;

  typedef struct {
    logic [DIST_W-1:0] d;
    logic [ID_W-1:0]   id;
    int                rank;
    bit                last;
  } beat_t;

  logic   clk = 1'b0;
  logic   rst_n;
  int     n_cmp = 0;
  int     n_err = 0;
  ent_t   mq[$];
  int     mst = 0;
  int     mr = 0;
  beat_t  beats[$];
  int     done_seen = 0;
  int     cyc = 0;
  int     last_beat_cyc = 0;
  int     done_cyc = 0;

  knn_topk_tracker_if #(.K(K), .DIST_W(DIST_W), .ID_W(ID_W)) bus();

  knn_topk_tracker #(.K(K), .DIST_W(DIST_W), .ID_W(ID_W)) dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
    end
  endtask

  // Reference insertion: position = number of entries no farther than d.
  function automatic void model_insert(input logic [DIST_W-1:0] d, input logic [ID_W-1:0] id);
    int   p;
    ent_t e;
    p = 0;
    foreach (mq[j]) if (mq[j].d <= d) p++;
    if (p < K) begin
      e.d  = d;
      e.id = id;
      mq.insert(p, e);
      if (mq.size() > K) void'(mq.pop_back());
    end
  endfunction

  // Model: 0 idle, 1 collecting, 2 draining, 3 finished.
  initial begin : p_model
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        mq.delete();
        mst = 0;
        mr  = 0;
      end else if (bus.query_start_in) begin
        mq.delete();
        mst = 1;
        mr  = 0;
      end else begin
        case (mst)
          1: begin
            if (bus.data_valid_in) model_insert(bus.distance_sq_in, bus.vertex_id_in);
            if (bus.query_done_in) begin
              mst = 2;
              mr  = 0;
            end
          end
          2: begin
            if (mq.size() == 0) mst = 3;
            else if (bus.result_ready_in) begin
              if (mr == mq.size() - 1) begin
                mst = 3;
                mr  = 0;
              end else begin
                mr++;
              end
            end
          end
          3: mst = 0;
          default: mst = 0;
        endcase
      end
    end
  end

  initial begin : p_compare
    bit    ev;
    beat_t b;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n === 1'b1) begin
        ev = (mst == 2) && (mq.size() != 0);
        chk("ready_out", 64'(bus.ready_out), 64'(mst == 1));
        chk("count_out", 64'(bus.count_out), 64'(mq.size()));
        chk("result_valid_out", 64'(bus.result_valid_out), 64'(ev));
        chk("done_out", 64'(bus.done_out), 64'((mst == 3) && !bus.query_start_in));
        if (ev) begin
          chk("result_dist_out", 64'(bus.result_dist_out), 64'(mq[mr].d));
          chk("result_id_out", 64'(bus.result_id_out), 64'(mq[mr].id));
          chk("result_rank_out", 64'(bus.result_rank_out), 64'(mr));
          chk("result_last_out", 64'(bus.result_last_out), 64'(mr == mq.size() - 1));
        end
        if (bus.result_valid_out && bus.result_ready_in) begin
          b.d    = bus.result_dist_out;
          b.id   = bus.result_id_out;
          b.rank = int'(bus.result_rank_out);
          b.last = bus.result_last_out;
          beats.push_back(b);
          if (b.last) last_beat_cyc = cyc;
        end
        if (bus.done_out) begin
          done_seen++;
          done_cyc = cyc;
        end
      end
    end
  end

  initial begin : p_watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic new_query();
    beats.delete();
    done_seen = 0;
    bus.query_start_in = 1'b1;
    tick();
    bus.query_start_in = 1'b0;
  endtask

  task automatic send(input logic [DIST_W-1:0] d, input logic [ID_W-1:0] id);
    bus.data_valid_in  = 1'b1;
    bus.distance_sq_in = d;
    bus.vertex_id_in   = id;
    tick();
    bus.data_valid_in  = 1'b0;
  endtask

  task automatic end_query();
    bus.query_done_in = 1'b1;
    tick();
    bus.query_done_in = 1'b0;
  endtask

  task automatic wait_done(input bit rand_rr);
    int n;
    n = 0;
    while (bus.done_out !== 1'b1 && n < 200) begin
      bus.result_ready_in = rand_rr ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      n++;
    end
    chk("done_within_budget", 64'(n < 200), 64'd1);
    bus.result_ready_in = 1'b1;
    tick();
  endtask

  task automatic chk_beat(input int i, input int d, input int id, input bit last);
    if (i < beats.size()) begin
      chk("beat_dist", 64'(beats[i].d), 64'(d));
      chk("beat_id", 64'(beats[i].id), 64'(id));
      chk("beat_rank", 64'(beats[i].rank), 64'(i));
      chk("beat_last", 64'(beats[i].last), 64'(last));
    end else begin
      chk("beat_present", 64'(beats.size()), 64'(i + 1));
    end
  endtask

  initial begin : p_main
    int nsamp;
    int sel;
    logic [DIST_W-1:0] rd;

    rst_n              = 1'b0;
    bus.query_start_in = 1'b0;
    bus.data_valid_in  = 1'b0;
    bus.distance_sq_in = '0;
    bus.vertex_id_in   = '0;
    bus.query_done_in  = 1'b0;
    bus.result_ready_in = 1'b1;
    repeat (3) tick();

    chk("rst_ready", 64'(bus.ready_out), 64'd0);
    chk("rst_count", 64'(bus.count_out), 64'd0);
    chk("rst_valid", 64'(bus.result_valid_out), 64'd0);
    chk("rst_done", 64'(bus.done_out), 64'd0);
    chk("rst_dist", 64'(bus.result_dist_out), 64'd0);
    chk("rst_last", 64'(bus.result_last_out), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Basic ordering
    new_query();
    send(50, 1); send(10, 2); send(30, 3); send(20, 4);
    end_query();
    wait_done(1'b0);
    chk("basic_beats", 64'(beats.size()), 64'd4);
    chk_beat(0, 10, 2, 1'b0);
    chk_beat(1, 20, 4, 1'b0);
    chk_beat(2, 30, 3, 1'b0);
    chk_beat(3, 50, 1, 1'b1);
    chk("basic_done_count", 64'(done_seen), 64'd1);
    chk("basic_done_delay", 64'(done_cyc - last_beat_cyc), 64'd1);

    // Overflow, discard beyond the list, and tie with the last slot
    new_query();
    send(50, 1); send(10, 2); send(30, 3); send(20, 4);
    send(5, 5); send(60, 6); send(30, 7);
    chk("ovf_count", 64'(bus.count_out), 64'd4);
    end_query();
    wait_done(1'b0);
    chk("ovf_beats", 64'(beats.size()), 64'd4);
    chk_beat(0, 5, 5, 1'b0);
    chk_beat(1, 10, 2, 1'b0);
    chk_beat(2, 20, 4, 1'b0);
    chk_beat(3, 30, 3, 1'b1);

    // Partial fill
    new_query();
    send(7, 9); send(3, 8);
    chk("partial_count", 64'(bus.count_out), 64'd2);
    end_query();
    wait_done(1'b0);
    chk("partial_beats", 64'(beats.size()), 64'd2);
    chk_beat(0, 3, 8, 1'b0);
    chk_beat(1, 7, 9, 1'b1);

    // Empty query
    new_query();
    end_query();
    wait_done(1'b0);
    chk("empty_beats", 64'(beats.size()), 64'd0);
    chk("empty_done", 64'(done_seen), 64'd1);

    // Backpressure on rank 1
    new_query();
    send(8, 1); send(6, 2); send(9, 3);
    end_query();
    tick();
    bus.result_ready_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", 64'(bus.result_valid_out), 64'd1);
      chk("bp_dist", 64'(bus.result_dist_out), 64'd8);
      chk("bp_id", 64'(bus.result_id_out), 64'd1);
      chk("bp_rank", 64'(bus.result_rank_out), 64'd1);
    end
    wait_done(1'b0);
    chk("bp_beats", 64'(beats.size()), 64'd3);

    // Sample arriving together with query_done
    new_query();
    send(9, 3);
    bus.data_valid_in  = 1'b1;
    bus.distance_sq_in = 1;
    bus.vertex_id_in   = 11;
    bus.query_done_in  = 1'b1;
    tick();
    bus.data_valid_in  = 1'b0;
    bus.query_done_in  = 1'b0;
    wait_done(1'b0);
    chk("simul_beats", 64'(beats.size()), 64'd2);
    chk_beat(0, 1, 11, 1'b0);

    // Restart with a sample during DRAIN
    new_query();
    send(4, 1); send(2, 2);
    end_query();
    bus.result_ready_in = 1'b0;
    tick(); tick();
    bus.query_start_in = 1'b1;
    bus.data_valid_in  = 1'b1;
    bus.distance_sq_in = 0;
    bus.vertex_id_in   = 99;
    tick();
    bus.query_start_in = 1'b0;
    bus.data_valid_in  = 1'b0;
    bus.result_ready_in = 1'b1;
    chk("abort_ready", 64'(bus.ready_out), 64'd1);
    chk("abort_count", 64'(bus.count_out), 64'd0);
    chk("abort_valid", 64'(bus.result_valid_out), 64'd0);
    chk("abort_no_done", 64'(done_seen), 64'd0);
    end_query();
    wait_done(1'b0);

    // Asynchronous reset between edges while draining
    new_query();
    send(3, 1); send(1, 2); send(2, 3);
    end_query();
    bus.result_ready_in = 1'b0;
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(bus.result_valid_out), 64'd0);
    chk("arst_count", 64'(bus.count_out), 64'd0);
    bus.result_ready_in = 1'b1;
    tick(); tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    new_query();
    send(12, 4); send(11, 5);
    end_query();
    wait_done(1'b0);
    chk_beat(0, 11, 5, 1'b0);
    chk_beat(1, 12, 4, 1'b1);

    // Randomized queries, including ties and extreme distances
    for (int q = 0; q < 40; q++) begin
      bus.data_valid_in  = 1'b1;
      bus.distance_sq_in = DIST_W'($urandom);
      bus.query_done_in  = 1'($urandom_range(0, 1));
      tick();
      bus.data_valid_in  = 1'b0;
      bus.query_done_in  = 1'b0;
      new_query();
      nsamp = $urandom_range(0, 10);
      for (int s = 0; s < nsamp; s++) begin
        if ($urandom_range(0, 3) == 0) tick();
        sel = $urandom_range(0, 7);
        rd  = (sel == 0) ? '0 : (sel == 1) ? '1 : DIST_W'($urandom_range(0, 20));
        send(rd, ID_W'($urandom));
        if (q % 9 == 4 && s == 2) new_query();
      end
      end_query();
      wait_done(1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/knn_topk_tracker.md
Name: knn_topk_tracker

Overview:
- Sits directly downstream of the squared-distance stage in the nearest-neighbour search datapath.
- Consumes one (distance_sq, vertex id) pair per cycle and maintains a sorted list of the K smallest distances for the current query.
- At end of query, streams the list out, nearest first, over a valid/ready handshake to the result/graph-walk controller.

Parameters:
- K, 4, number of nearest candidates retained (2..16).
- DIST_W, 32, distance_sq width; matches upstream distance_sq_out.
- ID_W, 16, vertex identifier width.

Ports:
- clk_in  input  1  system clock, all state on rising edge.
- rst_in  input  1  asynchronous, active-low reset.
- query_start_in  input  1  single-cycle pulse; clears list, begins new query.
- data_valid_in  input  1  distance sample valid; driven from upstream data_valid_out.
- distance_sq_in  input  DIST_W  squared distance, unsigned.
- vertex_id_in  input  ID_W  id of vertex that produced distance_sq_in.
- query_done_in  input  1  pulse; no further samples for this query.
- ready_out  input-side  output  1  high only in COLLECT; samples are accepted when data_valid_in && ready_out.
- count_out  output  $clog2(K+1)  number of filled slots.
- result_valid_out  output  1  result beat valid.
- result_ready_in  input  1  downstream accepts beat.
- result_dist_out  output  DIST_W  distance of current beat.
- result_id_out  output  ID_W  vertex id of current beat.
- result_rank_out  output  $clog2(K)  0 = nearest.
- result_last_out  output  1  final beat of query.
- done_out  output  1  one-cycle pulse after last beat accepted, or after an empty drain.

Behaviour:
- Reset (rst_in low, async): state IDLE; all slots invalid, dist/id cleared to 0; count_out 0; ready_out 0; result_valid_out 0, result_last_out 0, done_out 0, result_* data 0.
- FSM states: IDLE, COLLECT, DRAIN, FINISH.
- IDLE:
  - query_start_in -> COLLECT next edge.
  - data_valid_in and query_done_in ignored.
- COLLECT:
  - ready_out=1.
  - On accepted sample, insert in one cycle; visible in slots and count_out at the same clock edge.
  - Insertion position p = number of valid slots with dist <= distance_sq_in. Ties keep earlier arrival nearer.
  - Slots p..K-2 shift down one; slot K-1 drops.
  - If list is full and distance_sq_in >= slot[K-1].dist, the sample is discarded; no change.
  - count_out saturates at K.
  - query_done_in -> DRAIN next edge. If a sample is accepted in the same cycle, it is inserted first.
- DRAIN:
  - ready_out=0.
  - Rank counter r starts at 0; result_valid_out=1 with slot[r] data, rank=r, last=(r==count-1).
  - Beat completes when result_valid_out && result_ready_in; r increments.
  - Data holds stable while ready is low.
  - After the last beat completes -> FINISH.
  - If count==0 on entry: no beats; go straight to FINISH.
- FINISH:
  - done_out=1 for exactly one cycle -> IDLE.
  - List contents retained until the next query_start_in.
- query_start_in in COLLECT, DRAIN or FINISH aborts the current query:
  - list cleared, r=0, result_valid_out drops, done_out not asserted -> COLLECT next edge.
  - Priority over query_done_in and data_valid_in in the same cycle; that sample is discarded.
- data_valid_in outside COLLECT: dropped, no error flag.
- Arithmetic: unsigned compares only; distance 0 and all-ones are legal values.

Test Plan:
- Basic ordering, K=4:
  - Stimulus: start; samples (d,id) = (50,1),(10,2),(30,3),(20,4); done; ready held 1.
  - Required: beats (10,2,r0),(20,4,r1),(30,3,r2),(50,1,r3,last); done_out 1 cycle after the last beat.
- Overflow and discard:
  - Stimulus: after the above, samples (5,5),(60,6),(30,7).
  - Required: list (5,5),(10,2),(20,4),(30,3); 60 is discarded; the tie at 30 is discarded.
- Partial fill and empty:
  - Stimulus: start; samples (7,9),(3,8); done.
  - Required: 2 beats (3,8,r0),(7,9,r1,last); count_out 2.
  - Stimulus: start; done immediately.
  - Required: zero beats, done_out pulses.
- Backpressure:
  - Stimulus: hold result_ready_in low 5 cycles on beat r1.
  - Required: result_valid_out, result_dist_out, result_id_out and result_rank_out stable throughout.
- Simultaneous events:
  - Stimulus: data_valid_in (1,11) together with query_done_in.
  - Required: (1,11) emitted as rank 0.
  - Stimulus: query_start_in together with data_valid_in during DRAIN.
  - Required: list empty, state COLLECT, no done_out.
- Async reset mid-DRAIN:
  - Stimulus: drop rst_in between clock edges.
  - Required: result_valid_out 0 immediately; count_out 0; after release, a new query operates normally.
